// File: rtl/electrode_seq.sv
// electrode_seq: life-cycle sequencer for the electrode hazard sprite.
// Walks IDLE -> WARN (blinking) -> ACTIVE (solid, hazardous) -> COOL -> IDLE,
// counting display frame ticks in each phase, and latches the spawn position
// for the top-level offset logic. abort returns to IDLE from anywhere.
// Optional build macro: ELECTRODE_RETRIGGER_EN -- when defined, a trigger seen
// during COOL restarts the warning phase directly instead of being ignored.
module electrode_seq #(
    parameter int WARN_TICKS   = 90,
    parameter int ACTIVE_TICKS = 30,
    parameter int COOL_TICKS   = 60,
    parameter int BLINK_DIV    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       trigger,
    input  logic       abort,
    input  logic [6:0] spawn_x,
    input  logic [5:0] spawn_y,
    output logic [1:0] state,
    output logic       blink_clk,
    output logic       hazard,
    output logic       busy,
    output logic       done,
    output logic [6:0] pos_x,
    output logic [5:0] pos_y
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WARN   = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;
    localparam logic [1:0] ST_COOL   = 2'd3;

    // Terminal counts, compared against the 8-bit counters.
    localparam logic [7:0] WARN_LAST   = 8'(WARN_TICKS - 1);
    localparam logic [7:0] ACTIVE_LAST = 8'(ACTIVE_TICKS - 1);
    localparam logic [7:0] COOL_LAST   = 8'(COOL_TICKS - 1);
    localparam logic [7:0] BLINK_LAST  = 8'(BLINK_DIV - 1);

    logic [1:0] fsm_r, fsm_s;
    logic [7:0] tick_cnt_r, tick_cnt_s;
    logic [7:0] blink_cnt_r, blink_cnt_s;
    logic       blink_s;
    logic       done_s;
    logic [6:0] pos_x_s;
    logic [5:0] pos_y_s;
    logic [1:0] state_s;

    // Next-state, counter, blink and position logic for the sprite life cycle.
    always_comb begin
        fsm_s       = fsm_r;
        tick_cnt_s  = tick_cnt_r;
        blink_cnt_s = blink_cnt_r;
        blink_s     = blink_clk;
        done_s      = 1'b0;
        pos_x_s     = pos_x;
        pos_y_s     = pos_y;
        if (abort) begin
            // Kill: back to IDLE, no done pulse, position is kept.
            fsm_s       = ST_IDLE;
            tick_cnt_s  = 8'd0;
            blink_cnt_s = 8'd0;
            blink_s     = 1'b0;
        end else begin
            case (fsm_r)
                ST_IDLE: begin
                    // A frame_tick in the trigger cycle is deliberately not counted.
                    if (trigger) begin
                        fsm_s       = ST_WARN;
                        tick_cnt_s  = 8'd0;
                        blink_cnt_s = 8'd0;
                        blink_s     = 1'b1;
                        pos_x_s     = spawn_x;
                        pos_y_s     = spawn_y;
                    end else begin
                        tick_cnt_s  = 8'd0;
                        blink_cnt_s = 8'd0;
                        blink_s     = 1'b0;
                    end
                end
                ST_WARN: begin
                    if (frame_tick) begin
                        if (tick_cnt_r == WARN_LAST) begin
                            fsm_s       = ST_ACTIVE;
                            tick_cnt_s  = 8'd0;
                            blink_cnt_s = 8'd0;
                            blink_s     = 1'b0;
                        end else begin
                            tick_cnt_s = tick_cnt_r + 8'd1;
                            if (blink_cnt_r == BLINK_LAST) begin
                                blink_s     = ~blink_clk;
                                blink_cnt_s = 8'd0;
                            end else begin
                                blink_cnt_s = blink_cnt_r + 8'd1;
                            end
                        end
                    end else begin
                        fsm_s = ST_WARN;
                    end
                end
                ST_ACTIVE: begin
                    if (frame_tick) begin
                        if (tick_cnt_r == ACTIVE_LAST) begin
                            fsm_s      = ST_COOL;
                            tick_cnt_s = 8'd0;
                        end else begin
                            tick_cnt_s = tick_cnt_r + 8'd1;
                        end
                    end else begin
                        fsm_s = ST_ACTIVE;
                    end
                end
                ST_COOL: begin
`ifdef ELECTRODE_RETRIGGER_EN
                    // Re-trigger wins over a coincident terminal tick; no done pulse.
                    if (trigger) begin
                        fsm_s       = ST_WARN;
                        tick_cnt_s  = 8'd0;
                        blink_cnt_s = 8'd0;
                        blink_s     = 1'b1;
                        pos_x_s     = spawn_x;
                        pos_y_s     = spawn_y;
                    end else if (frame_tick) begin
`else
                    if (frame_tick) begin
`endif
                        if (tick_cnt_r == COOL_LAST) begin
                            fsm_s      = ST_IDLE;
                            tick_cnt_s = 8'd0;
                            done_s     = 1'b1;
                        end else begin
                            tick_cnt_s = tick_cnt_r + 8'd1;
                        end
                    end else begin
                        fsm_s = ST_COOL;
                    end
                end
                default: begin
                    fsm_s       = ST_IDLE;
                    tick_cnt_s  = 8'd0;
                    blink_cnt_s = 8'd0;
                    blink_s     = 1'b0;
                end
            endcase
        end
    end

    // Renderer state encoding derived from the next FSM state.
    always_comb begin
        case (fsm_s)
            ST_WARN:   state_s = 2'b01;
            ST_ACTIVE: state_s = 2'b10;
            default:   state_s = 2'b00;
        endcase
    end

    // State register and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_r       <= ST_IDLE;
            tick_cnt_r  <= 8'd0;
            blink_cnt_r <= 8'd0;
            state       <= 2'b00;
            blink_clk   <= 1'b0;
            hazard      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pos_x       <= 7'd0;
            pos_y       <= 6'd0;
        end else begin
            fsm_r       <= fsm_s;
            tick_cnt_r  <= tick_cnt_s;
            blink_cnt_r <= blink_cnt_s;
            state       <= state_s;
            blink_clk   <= blink_s;
            hazard      <= (fsm_s == ST_ACTIVE);
            busy        <= (fsm_s != ST_IDLE);
            done        <= done_s;
            pos_x       <= pos_x_s;
            pos_y       <= pos_y_s;
        end
    end

endmodule

// File: tb/tb_electrode_seq.sv
// tb_electrode_seq: directed self-checking bench for electrode_seq with
// WARN=4, ACTIVE=2, COOL=3, BLINK_DIV=2 and a frame tick every 4th cycle.
// Outputs are packed as {state[1:0], blink_clk, hazard, busy, done}.
module tb_electrode_seq;

    logic       clk;
    logic       rst_n;
    logic       frame_tick;
    logic       trigger;
    logic       abort;
    logic [6:0] spawn_x;
    logic [5:0] spawn_y;
    logic [1:0] state;
    logic       blink_clk;
    logic       hazard;
    logic       busy;
    logic       done;
    logic [6:0] pos_x;
    logic [5:0] pos_y;

    int errors = 0;
    int checks = 0;

    localparam logic [5:0] W_IDLE   = 6'b00_0_0_0_0;
    localparam logic [5:0] W_WARN1  = 6'b01_1_0_1_0;
    localparam logic [5:0] W_WARN0  = 6'b01_0_0_1_0;
    localparam logic [5:0] W_ACTIVE = 6'b10_0_1_1_0;
    localparam logic [5:0] W_COOL   = 6'b00_0_0_1_0;
    localparam logic [5:0] W_DONE   = 6'b00_0_0_0_1;

    electrode_seq #(
        .WARN_TICKS(4), .ACTIVE_TICKS(2), .COOL_TICKS(3), .BLINK_DIV(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .trigger(trigger),
        .abort(abort), .spawn_x(spawn_x), .spawn_y(spawn_y), .state(state),
        .blink_clk(blink_clk), .hazard(hazard), .busy(busy), .done(done),
        .pos_x(pos_x), .pos_y(pos_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [5:0] exp);
        chk(tag, {26'd0, state, blink_clk, hazard, busy, done}, {26'd0, exp});
    endtask

    task automatic chk_pos(input string tag, input logic [6:0] x, input logic [5:0] y);
        chk(tag, {19'd0, pos_x, pos_y}, {19'd0, x, y});
    endtask

    // One clock: inputs already set at the falling edge, ends at the next falling edge.
    task automatic cycle(input logic ft);
        frame_tick = ft;
        @(posedge clk);
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    // One display frame: three quiet cycles then a tick cycle.
    task automatic frame();
        cycle(1'b0);
        cycle(1'b0);
        cycle(1'b0);
        cycle(1'b1);
    endtask

    task automatic start(input logic [6:0] x, input logic [5:0] y);
        spawn_x = x;
        spawn_y = y;
        trigger = 1'b1;
        cycle(1'b0);
        trigger = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; frame_tick = 1'b0; trigger = 1'b0; abort = 1'b0;
        spawn_x = 7'd0; spawn_y = 6'd0;
        @(negedge clk);
        @(negedge clk);
        chk_out("reset_outputs", W_IDLE);
        chk_pos("reset_pos", 7'd0, 6'd0);
        rst_n = 1'b1;
        cycle(1'b1);
        chk_out("idle_tick_no_trigger", W_IDLE);

        // Full cycle with blink pattern 1,1,0,0 across the WARN ticks.
        start(7'd50, 6'd20);
        chk_out("warn_entry", W_WARN1);
        chk_pos("warn_entry_pos", 7'd50, 6'd20);
        frame(); chk_out("warn_tick0", W_WARN1);
        frame(); chk_out("warn_tick1", W_WARN0);
        frame(); chk_out("warn_tick2", W_WARN0);
        frame(); chk_out("active_entry", W_ACTIVE);
        frame(); chk_out("active_tick0", W_ACTIVE);
        frame(); chk_out("cool_entry", W_COOL);
        chk_pos("cool_pos", 7'd50, 6'd20);
        frame(); chk_out("cool_tick0", W_COOL);
        frame(); chk_out("cool_tick1", W_COOL);
        frame(); chk_out("done_pulse", W_DONE);
        chk_pos("done_pos", 7'd50, 6'd20);

        // Back-to-back: trigger while done is high is accepted.
        start(7'd30, 6'd7);
        chk_out("b2b_warn_entry", W_WARN1);
        chk_pos("b2b_pos", 7'd30, 6'd7);

        // Trigger during WARN is ignored and WARN keeps its 4-tick length.
        spawn_x = 7'd10; spawn_y = 6'd5; trigger = 1'b1;
        frame();
        trigger = 1'b0;
        chk_out("warn_retrig_ignored", W_WARN1);
        chk_pos("warn_retrig_pos", 7'd30, 6'd7);
        frame(); chk_out("warn2_tick1", W_WARN0);
        frame(); chk_out("warn2_tick2", W_WARN0);
        frame(); chk_out("warn2_active", W_ACTIVE);

        // Abort in ACTIVE after one tick.
        frame(); chk_out("active2_tick0", W_ACTIVE);
        abort = 1'b1;
        cycle(1'b0);
        abort = 1'b0;
        chk_out("abort_idle", W_IDLE);
        chk_pos("abort_pos_kept", 7'd30, 6'd7);
        cycle(1'b0);
        chk_out("abort_no_done", W_IDLE);

        // Trigger and abort together in IDLE: stays IDLE, no latch.
        spawn_x = 7'd1; spawn_y = 6'd1; trigger = 1'b1; abort = 1'b1;
        cycle(1'b0);
        trigger = 1'b0; abort = 1'b0;
        chk_out("trig_abort_idle", W_IDLE);
        chk_pos("trig_abort_pos", 7'd30, 6'd7);

        // Trigger in COOL.
        start(7'd50, 6'd20);
        frame(); frame(); frame(); frame();
        frame(); frame();
        chk_out("cool2_entry", W_COOL);
        frame();
        chk_out("cool2_tick0", W_COOL);
        start(7'd9, 6'd9);
`ifdef ELECTRODE_RETRIGGER_EN
        chk_out("cool_retrig_warn", W_WARN1);
        chk_pos("cool_retrig_pos", 7'd9, 6'd9);
        cycle(1'b0);
        chk_out("cool_retrig_no_done", W_WARN1);
        abort = 1'b1;
        cycle(1'b0);
        abort = 1'b0;
        chk_out("cool_retrig_cleanup", W_IDLE);
`else
        chk_out("cool_retrig_ignored", W_COOL);
        chk_pos("cool_retrig_pos", 7'd50, 6'd20);
        frame(); chk_out("cool2_tick1", W_COOL);
        frame(); chk_out("cool2_done", W_DONE);
`endif
        cycle(1'b0);
        chk_out("idle_after_cool", W_IDLE);

        // Async reset pulse in WARN, between clock edges.
        start(7'd50, 6'd20);
        frame();
        chk_out("pre_reset_warn", W_WARN1);
        #2 rst_n = 1'b0;
        #1;
        chk_out("async_reset_outputs", W_IDLE);
        chk_pos("async_reset_pos", 7'd0, 6'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        start(7'd50, 6'd20);
        chk_out("post_reset_warn", W_WARN1);
        frame(); chk_out("post_reset_tick0", W_WARN1);
        frame(); chk_out("post_reset_tick1", W_WARN0);
        frame(); chk_out("post_reset_tick2", W_WARN0);
        frame(); chk_out("post_reset_active", W_ACTIVE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/electrode_seq.md
# electrode_seq

- Sequencing controller for the electrode hazard sprite.
- Drives the sprite renderer's `state[1:0]` and `blink_clk` inputs through a fixed life cycle: idle, blinking warning, solid/live, cooldown.
- Latches the spawn position for the top-level offset logic.
- Exports a `hazard` flag that the collision logic uses while the electrode is live.

## Interface
- `WARN_TICKS`, 90: frame ticks spent in WARN (≥1, ≤255).
- `ACTIVE_TICKS`, 30: frame ticks spent in ACTIVE (≥1, ≤255).
- `COOL_TICKS`, 60: frame ticks spent in COOL (≥1, ≤255).
- `BLINK_DIV`, 8: frame ticks per blink half-period (≥1, ≤255).
- `clk` in 1: system clock; one clock domain, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `frame_tick` in 1: one-cycle pulse per display frame.
- `trigger` in 1: spawn request, level sampled each cycle.
- `abort` in 1: synchronous kill, e.g. on player death.
- `spawn_x` in 7: requested sprite x position.
- `spawn_y` in 6: requested sprite y position.
- `state` out 2: sprite state. 00 = hidden, 01 = blinking, 10 = solid. 11 is never driven.
- `blink_clk` out 1: blink phase used by the renderer.
- `hazard` out 1: high exactly while in ACTIVE.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when a cycle completes normally.
- `pos_x` out 7: latched x position.
- `pos_y` out 6: latched y position.

## Operation
- FSM states: IDLE, WARN, ACTIVE, COOL. All outputs are registered.
- Output `state` per FSM state: IDLE → 00, WARN → 01, ACTIVE → 10, COOL → 00.
- An 8-bit `tick_cnt` counts only `frame_tick` pulses. It clears on every state entry.
- IDLE, on `trigger`:
  - Go to WARN.
  - Latch `pos_x`/`pos_y` from `spawn_x`/`spawn_y`.
  - Clear `tick_cnt` and `blink_cnt`; set `blink_clk` = 1.
  - A `frame_tick` in the same cycle is not counted.
- WARN:
  - On `frame_tick`, increment `tick_cnt` and `blink_cnt`.
  - When `blink_cnt` == BLINK_DIV-1 on a tick, toggle `blink_clk` and clear `blink_cnt`.
  - When `tick_cnt` == WARN_TICKS-1 on a tick, go to ACTIVE.
- ACTIVE:
  - `hazard` = 1.
  - When `tick_cnt` == ACTIVE_TICKS-1 on a tick, go to COOL.
- COOL: when `tick_cnt` == COOL_TICKS-1 on a tick, go to IDLE and pulse `done` for one cycle.
- `blink_clk` is 0 in every state except WARN.
- `trigger` in WARN or ACTIVE is ignored. `trigger` in COOL is governed by Configuration.
- `abort`:
  - Highest priority.
  - From any state, go to IDLE next cycle. Clear counters, `blink_clk`, `hazard` and `busy`.
  - No `done` pulse.
  - `pos_x`/`pos_y` keep their values.
- `trigger` and `abort` in the same cycle: abort wins and the trigger is dropped.
- Reset values: FSM = IDLE, `state` = 00, `blink_clk` = 0, `hazard` = 0, `busy` = 0, `done` = 0, `pos_x` = 0, `pos_y` = 0, all counters = 0.
- Reset asserted mid-cycle returns all of the above immediately, asynchronously.

## Timing
- Trigger accepted on edge N: `state`, `busy` and `blink_clk` reflect WARN from edge N onward (1-cycle latency).
- Transitions occur on the clock edge that samples the terminal `frame_tick`. WARN lasts exactly WARN_TICKS ticks after entry, with no off-by-one.
- `done` is high only in the cycle after the last COOL tick, concurrent with `busy` = 0. It is never high for two consecutive cycles.
- Back-to-back cycles: `trigger` high in the same cycle `done` is high is accepted, because the FSM is already in IDLE.
- `frame_tick` is never required to be spaced; consecutive-cycle ticks are counted individually.

## Configuration
- `ELECTRODE_RETRIGGER_EN` defined: `trigger` in COOL without `abort` goes directly to WARN.
  - Re-latches the position and clears counters.
  - Sets `blink_clk` = 1.
  - Emits no `done` pulse.
- `ELECTRODE_RETRIGGER_EN` undefined: `trigger` in COOL is ignored. A new cycle requires the return to IDLE.

## Test plan
All scenarios use WARN_TICKS = 4, ACTIVE_TICKS = 2, COOL_TICKS = 3, BLINK_DIV = 2, and `frame_tick` every 4th cycle.

- Full cycle: trigger with spawn (50, 20) → `state` 01 for 4 ticks, then 10 for 2 ticks with `hazard` = 1, then 00 for 3 ticks. Expect a single `done` pulse, `busy` = 0, and `pos` = (50, 20) throughout.
- Blink: during WARN, `blink_clk` = 1, 1, 0, 0 across ticks 0–3, and 0 on entry to ACTIVE.
- Abort in ACTIVE after 1 tick → next cycle `state` = 00, `hazard` = 0, `busy` = 0, no `done`. Trigger + abort in the same cycle in IDLE → stays IDLE.
- Trigger during WARN with spawn (10, 5) → ignored; `pos` unchanged and WARN length still 4 ticks. Trigger in COOL → with the macro, WARN next cycle and no `done`; without it, ignored.
- Async reset pulse in WARN, asserted between clock edges → all outputs 0 immediately. After release, a trigger starts a clean 4-tick WARN.
